ex_wb_stage: RTL and testbench
==============================

# ex_wb_stage

Execute/write-back stage directly downstream of the ALU. Captures each ALU result with its destination and control tags into a 2-entry in-order buffer using a valid/ready handshake. Drives the register-file write port, the branch-taken pulse, a sticky divide-by-zero error flag, and a forwarding bus back to operand selection.

## Interface
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, register index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  ALU output tagged valid this cycle
- in_ready  out  1  stage can accept; equals (count != 2)
- in_result  in  DATA_W  ALU result
- in_zero  in  1  ALU zero flag
- in_alu_control  in  4  ALU op code of this result
- in_src2_zero  in  1  second ALU operand was 0
- in_rd  in  REG_ADDR_W  destination register
- in_reg_write  in  1  instruction writes rd
- in_branch  in  1  instruction is branch-if-equal
- flush  in  1  discard all buffered entries
- err_clear  in  1  clears div_zero_err
- wb_ready  in  1  register-file write port available
- wb_we  out  1  register write strobe
- wb_addr  out  REG_ADDR_W  write index
- wb_data  out  DATA_W  write data
- branch_taken  out  1  one-cycle pulse on retire of a taken branch
- div_zero_err  out  1  sticky divide-by-zero flag
- fwd_valid  out  1  fwd_rd/fwd_data hold a pending write
- fwd_rd  out  REG_ADDR_W  youngest pending destination
- fwd_data  out  DATA_W  youngest pending result
- count  out  2  occupancy, 0..2

## Operation
- Entry = {result, zero, div0, rd, reg_write, branch}; div0 = (in_alu_control == DIV) && in_src2_zero, computed at push.
- Push: in_valid && in_ready && !flush. Retire: (count != 0) && wb_ready && !flush.
- in_ready depends on count only. At count 2, no push even when retiring in the same cycle.
- Head = oldest entry. On retire:
  - wb_we = head.reg_write && head.rd != 0 && !head.div0
  - wb_addr = head.rd; wb_data = head.result
  - branch_taken = head.branch && head.zero
  - div_zero_err set if head.div0
- wb_addr and wb_data show the head whenever count != 0, and 0 when empty. wb_we and branch_taken are 0 whenever no retire occurs.
- Forwarding sources the tail (youngest) entry: fwd_valid = count != 0 && tail.reg_write && tail.rd != 0 && !tail.div0. fwd_rd and fwd_data are 0 when fwd_valid = 0.
- flush has priority over both push and retire. Next state: count 0, pointers 0. Same-cycle input is dropped. div_zero_err is unaffected.
- div_zero_err: set on retire of a div0 entry; cleared by err_clear. Set wins when both occur in the same cycle.
- Results are never modified; width is DATA_W throughout.

## Timing
- Reset (async assert, sync release): count 0, pointers 0, div_zero_err 0, every output 0 except in_ready = 1.
- Latency: push at edge N into an empty stage → wb_we valid in cycle N+1 when wb_ready = 1.
- Throughput: 1 per cycle with wb_ready held high. Count holds at 1 under simultaneous push and retire.
- wb_ready low: entries hold. Count reaches 2 after two pushes, then in_ready = 0.
- Pointers wrap modulo 2. Order is strictly preserved.
- Reset mid-operation: all contents lost immediately. No write strobe is produced during or after assertion.

## Structure
- Shared package alu_pkg:
  - ALU op constants ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_MUL = 4'b1000, ALU_DIV = 4'b1001, ALU_MOVI = 4'b0000
  - DATA_W and REG_ADDR_W defaults
  - entry struct typedef
- Sub-module wb_fifo2: 2-entry storage, pointers, count, head/tail views.
- The top level holds the handshake, write-back decode, error flag and forwarding logic.

## Test plan
- Reset, then push {result = 0x0000_0007, rd = 3, reg_write = 1} → next cycle wb_we = 1, wb_addr = 3, wb_data = 7, count returns to 0.
- wb_ready = 0; push 0x11 (rd 1), 0x22 (rd 2), offer a third → in_ready = 0 at count 2, third not taken. Raise wb_ready → 0x11 then 0x22 retire on consecutive cycles. fwd shows rd 2 / 0x22 while both are buffered.
- Push DIV with in_src2_zero = 1, rd = 5 → on retire wb_we = 0, div_zero_err = 1 and stays set. err_clear pulse → 0.
- Push branch with in_zero = 1 → branch_taken pulses for one cycle at retire. The same entry with in_zero = 0 produces no pulse.
- Fill to 2, assert flush with in_valid = 1 → next cycle count = 0, no wb_we, flushed input is absent.
- Push to rd = 0 with reg_write = 1 → wb_we = 0 and fwd_valid = 0. Assert rst_n = 0 with count 2 → outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, default widths and the write-back entry record.
package alu_pkg;

    localparam logic [3:0] ALU_MOVI = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]     result;
        logic                      zero;
        logic                      div0;
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic                      reg_write;
        logic                      branch;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer; head is the oldest entry, tail the youngest.
module wb_fifo2
    import alu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t push_entry,
    output wb_entry_t head,
    output wb_entry_t tail,
    output logic [1:0] count
);

    wb_entry_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;

    // Single-bit pointers wrap naturally; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign tail = mem[~wr_ptr];

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/write-back stage: buffers ALU results and drives register write-back,
// branch-taken pulse, sticky divide-by-zero flag and the forwarding bus.
module ex_wb_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_zero,
    input  logic [3:0]            in_alu_control,
    input  logic                  in_src2_zero,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_branch,
    input  logic                  flush,
    input  logic                  err_clear,
    input  logic                  wb_ready,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  branch_taken,
    output logic                  div_zero_err,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data,
    output logic [1:0]            count
);

    wb_entry_t new_entry;
    wb_entry_t head;
    wb_entry_t tail;
    logic      push;
    logic      pop;
    logic      not_empty;

    assign not_empty = (count != 2'd0);
    assign in_ready  = (count != 2'd2);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = not_empty && wb_ready && !flush;

    always_comb begin
        new_entry           = '0;
        new_entry.result    = in_result;
        new_entry.zero      = in_zero;
        new_entry.div0      = (in_alu_control == ALU_DIV) && in_src2_zero;
        new_entry.rd        = in_rd;
        new_entry.reg_write = in_reg_write;
        new_entry.branch    = in_branch;
    end

    wb_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (new_entry),
        .head       (head),
        .tail       (tail),
        .count      (count)
    );

    // A divide-by-zero result is never written, and x0 is never written.
    assign wb_we        = pop && head.reg_write && (head.rd != '0) && !head.div0;
    assign wb_addr      = not_empty ? head.rd : '0;
    assign wb_data      = not_empty ? head.result : '0;
    assign branch_taken = pop && head.branch && head.zero;

    assign fwd_valid = not_empty && tail.reg_write && (tail.rd != '0) && !tail.div0;
    assign fwd_rd    = fwd_valid ? tail.rd : '0;
    assign fwd_data  = fwd_valid ? tail.result : '0;

    // Setting wins over a same-cycle clear so no error is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_zero_err <= 1'b0;
        end else if (pop && head.div0) begin
            div_zero_err <= 1'b1;
        end else if (err_clear) begin
            div_zero_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed testbench for ex_wb_stage with a queue-based scoreboard model.
module tb_ex_wb_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic [3:0]  in_alu_control;
    logic        in_src2_zero;
    logic [4:0]  in_rd;
    logic        in_reg_write, in_branch;
    logic        flush, err_clear, wb_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        branch_taken, div_zero_err, fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [1:0]  count;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        div0;
        logic [4:0]  rd;
        logic        reg_write;
        logic        branch;
    } exp_t;

    exp_t sb[$];
    logic m_err;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_zero        (in_zero),
        .in_alu_control (in_alu_control),
        .in_src2_zero   (in_src2_zero),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_branch      (in_branch),
        .flush          (flush),
        .err_clear      (err_clear),
        .wb_ready       (wb_ready),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .branch_taken   (branch_taken),
        .div_zero_err   (div_zero_err),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .count          (count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] res, input logic z,
                                 input logic [3:0] ctl, input logic s2z, input logic [4:0] rd,
                                 input logic rw, input logic br, input logic wr,
                                 input logic fl, input logic ec);
        in_valid       = v;
        in_result      = res;
        in_zero        = z;
        in_alu_control = ctl;
        in_src2_zero   = s2z;
        in_rd          = rd;
        in_reg_write   = rw;
        in_branch      = br;
        wb_ready       = wr;
        flush          = fl;
        err_clear      = ec;
    endtask

    task automatic idle(input logic wr);
        applyStimulus(1'b0, 32'h0, 1'b0, ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b0, wr, 1'b0, 1'b0);
    endtask

    task automatic pushOp(input logic [31:0] res, input logic [4:0] rd, input logic wr);
        applyStimulus(1'b1, res, 1'b0, ALU_ADD, 1'b0, rd, 1'b1, 1'b0, wr, 1'b0, 1'b0);
    endtask

    // Compare every output against the scoreboard model for the current cycle.
    task automatic checkAll();
        int   n;
        logic ret;
        logic fv;
        exp_t h;
        exp_t t;
        n   = sb.size();
        h   = '{default: '0};
        t   = '{default: '0};
        if (n != 0) begin
            h = sb[0];
            t = sb[n-1];
        end
        ret = (n != 0) && wb_ready && !flush;
        fv  = (n != 0) && t.reg_write && (t.rd != 5'd0) && !t.div0;
        checkOutput("count",        32'(count),        32'(n));
        checkOutput("in_ready",     32'(in_ready),     32'(n != 2));
        checkOutput("wb_we",        32'(wb_we),        32'(ret && h.reg_write && h.rd != 5'd0 && !h.div0));
        checkOutput("wb_addr",      32'(wb_addr),      32'(h.rd));
        checkOutput("wb_data",      wb_data,           h.result);
        checkOutput("branch_taken", 32'(branch_taken), 32'(ret && h.branch && h.zero));
        checkOutput("div_zero_err", 32'(div_zero_err), 32'(m_err));
        checkOutput("fwd_valid",    32'(fwd_valid),    32'(fv));
        checkOutput("fwd_rd",       32'(fwd_rd),       fv ? 32'(t.rd) : 32'h0);
        checkOutput("fwd_data",     fwd_data,          fv ? t.result : 32'h0);
    endtask

    task automatic updateModel();
        int   n;
        logic ret;
        exp_t e;
        n   = sb.size();
        ret = (n != 0) && wb_ready && !flush;
        if (ret && sb[0].div0) m_err = 1'b1;
        else if (err_clear)    m_err = 1'b0;
        if (flush) begin
            sb.delete();
        end else begin
            if (ret) void'(sb.pop_front());
            if (in_valid && n != 2) begin
                e.result    = in_result;
                e.zero      = in_zero;
                e.div0      = (in_alu_control == ALU_DIV) && in_src2_zero;
                e.rd        = in_rd;
                e.reg_write = in_reg_write;
                e.branch    = in_branch;
                sb.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkAll();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_err = 1'b0;
        rst_n = 1'b0;
        idle(1'b1);
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Single push retires the next cycle
        pushOp(32'h0000_0007, 5'd3, 1'b1);
        cycle();
        idle(1'b1);
        cycle();
        cycle();

        // Back-pressure: fill to two, third offer refused
        pushOp(32'h11, 5'd1, 1'b0);
        cycle();
        pushOp(32'h22, 5'd2, 1'b0);
        cycle();
        pushOp(32'h33, 5'd3, 1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();
        cycle();

        // Divide by zero: no write, sticky error, cleared by err_clear
        applyStimulus(1'b1, 32'hDEAD, 1'b0, ALU_DIV, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();
        cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, ALU_ADD, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        idle(1'b1);
        cycle();

        // Branch taken and not taken
        applyStimulus(1'b1, 32'h0, 1'b1, ALU_SUB, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();
        applyStimulus(1'b1, 32'h4, 1'b0, ALU_SUB, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();

        // Flush with a full buffer and a same-cycle offer
        pushOp(32'hA1, 5'd7, 1'b0);
        cycle();
        pushOp(32'hA2, 5'd8, 1'b0);
        cycle();
        applyStimulus(1'b1, 32'hA3, 1'b0, ALU_ADD, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();

        // Streaming at one per cycle
        for (int i = 0; i < 4; i++) begin
            pushOp(32'h100 + 32'(i), 5'(10 + i), 1'b1);
            cycle();
        end
        idle(1'b1);
        cycle();
        cycle();

        // Write to x0 is suppressed
        pushOp(32'h55, 5'd0, 1'b0);
        cycle();
        idle(1'b0);
        cycle();
        idle(1'b1);
        cycle();
        cycle();

        // Asynchronous reset with two entries buffered
        pushOp(32'hB1, 5'd12, 1'b0);
        cycle();
        pushOp(32'hB2, 5'd13, 1'b0);
        cycle();
        idle(1'b1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_err = 1'b0;
        #1;
        checkAll();
        @(posedge clk);
        #1;
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
